// File: rtl/cfs_apb_master.sv
// APB master: turns a valid/ready request channel into single APB transfers
// and returns read data plus error/timeout status on a valid/ready response channel.
module cfs_apb_master #(
    parameter int CFS_APB_MAX_ADDR_WIDTH = 16,
    parameter int CFS_APB_MAX_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES         = 255
) (
    input  logic                              pclk,
    input  logic                              preset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [CFS_APB_MAX_ADDR_WIDTH-1:0] req_addr,
    input  logic [CFS_APB_MAX_DATA_WIDTH-1:0] req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [CFS_APB_MAX_DATA_WIDTH-1:0] rsp_rdata,
    output logic                              rsp_err,
    output logic                              rsp_timeout,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [CFS_APB_MAX_ADDR_WIDTH-1:0] paddr,
    output logic [CFS_APB_MAX_DATA_WIDTH-1:0] pwdata,
    input  logic                              pready,
    input  logic [CFS_APB_MAX_DATA_WIDTH-1:0] prdata,
    input  logic                              pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CFS_APB_MAX_ADDR_WIDTH-1:0] ADDR_MASK = ~(CFS_APB_MAX_ADDR_WIDTH'(3));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_hit_s;

    // A zero threshold disables the abort path entirely.
    assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LIMIT);

    // Transfer sequencer; every bus and response output is a register updated here.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        pwrite    <= req_write;
                        paddr     <= req_addr & ADDR_MASK;
                        pwdata    <= req_wdata;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        cnt_r     <= '0;
                        req_ready <= 1'b0;
                        state_r   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    // pready has priority over a timeout reached in the same cycle.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state_r     <= RESP;
                    end else if (timeout_hit_s) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfs_apb_master.sv
// Self-checking bench for cfs_apb_master: directed plan scenarios plus randomized
// transfers compared against an outcome model derived from wait count and threshold.
module tb_cfs_apb_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int checks = 0;
    int errors = 0;

    cfs_apb_master #(
        .CFS_APB_MAX_ADDR_WIDTH(AW),
        .CFS_APB_MAX_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Waits for req_ready (bounded) and presents one request for exactly one accepting edge.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd, output bit ok);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        checks++;
        ok = (req_ready === 1'b1);
        if (!ok) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        end else begin
            req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
            @(negedge pclk);
            // Upstream fields become don't-care once accepted; scramble them.
            req_valid = 1'b0; req_write = ~wr;
            req_addr  = 16'($urandom); req_wdata = $urandom;
        end
    endtask

    task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input int waits, input bit serr, input logic [DW-1:0] rd, input int bp);
        bit            ok;
        int            acc;
        bit            exp_to;
        int            exp_acc;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        logic [AW-1:0] exp_addr;
        // Reference outcome: abort iff the slave stalls past the threshold.
        exp_to    = (waits > TO);
        exp_acc   = exp_to ? TO + 1 : waits + 1;
        exp_rdata = (exp_to || wr) ? 32'd0 : rd;
        exp_err   = exp_to ? 1'b1 : serr;
        exp_addr  = {addr[AW-1:2], 2'b00};

        rsp_ready = 1'b0;
        issue(wr, addr, wd, ok);
        if (ok) begin
            checks++;
            if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, wr, exp_addr} || (wr && pwdata !== wd)) begin
                errors++;
                $display("FAIL setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required 1 0 %b %h %h",
                         psel, penable, pwrite, paddr, pwdata, wr, exp_addr, wd);
            end
            pready = 1'($urandom); pslverr = 1'($urandom);
            @(negedge pclk);
            acc = 0;
            while (psel === 1'b1 && penable === 1'b1 && acc < 50) begin
                acc++;
                checks++;
                if (paddr !== exp_addr || pwrite !== wr || (wr && pwdata !== wd)) begin
                    errors++;
                    $display("FAIL access_hold: paddr=%h pwrite=%b required %h %b", paddr, pwrite, exp_addr, wr);
                end
                pready  = (acc > waits);
                prdata  = pready ? rd : $urandom;
                pslverr = pready ? serr : 1'($urandom);
                @(negedge pclk);
            end
            pready = 1'b0; pslverr = 1'b0;
            checks++;
            if (acc !== exp_acc) begin
                errors++;
                $display("FAIL access_cycles: got %0d required %0d", acc, exp_acc);
            end
            for (int i = 0; i <= bp; i++) begin
                checks++;
                if ({rsp_valid, psel, penable, req_ready} !== 4'b1000 || rsp_rdata !== exp_rdata ||
                    rsp_err !== exp_err || rsp_timeout !== exp_to) begin
                    errors++;
                    $display("FAIL resp[%0d]: valid=%b psel=%b pen=%b rdy=%b rdata=%h err=%b to=%b required 1 0 0 0 %h %b %b",
                             i, rsp_valid, psel, penable, req_ready, rsp_rdata, rsp_err, rsp_timeout,
                             exp_rdata, exp_err, exp_to);
                end
                if (i < bp) begin
                    // Requests offered during RESP must be ignored.
                    req_valid = 1'b1;
                    @(negedge pclk);
                end
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge pclk);
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 1'b0) begin
                errors++;
                $display("FAIL back_to_idle: rsp_valid=%b req_ready=%b psel=%b required 0 1 0",
                         rsp_valid, req_ready, psel);
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_values: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rdy=%b rv=%b rdata=%h err=%b to=%b required all 0",
                     psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
        preset = 1'b0;
    endtask

    task automatic test_directed();
        run_xfer(1'b1, 16'h0013, 32'hDEAD_BEEF, 0, 1'b0, 32'h1111_2222, 0); // zero-wait write
        run_xfer(1'b0, 16'h0100, 32'h0, 3, 1'b0, 32'hA5A5_1234, 0);         // 3 wait states
        run_xfer(1'b0, 16'h0204, 32'h0, 1, 1'b1, 32'h0BAD_F00D, 0);         // slave error
        run_xfer(1'b0, 16'h0300, 32'h0, 10, 1'b0, 32'h1234_5678, 0);        // timeout
        run_xfer(1'b1, 16'h0304, 32'h5555_AAAA, 10, 1'b0, 32'h0, 0);        // write timeout
        run_xfer(1'b0, 16'h0308, 32'h0, TO, 1'b0, 32'hCAFE_0001, 0);        // pready at threshold
        run_xfer(1'b1, 16'h040E, 32'h0F0F_F0F0, 0, 1'b0, 32'h0, 5);         // backpressure
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        pready = 1'b0;
        issue(1'b0, 16'h0500, 32'h0, ok);
        if (ok) begin
            repeat (2) @(negedge pclk);
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_access: psel=%b penable=%b required 1 1", psel, penable);
            end
            preset = 1'b1;
            @(negedge pclk);
            checks++;
            if ({psel, penable, rsp_valid, req_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_access: psel=%b pen=%b rsp_valid=%b req_ready=%b required 0 0 0 0",
                         psel, penable, rsp_valid, req_ready);
            end
            preset = 1'b0;
        end
        run_xfer(1'b0, 16'h0504, 32'h0, 2, 1'b0, 32'h7777_8888, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_xfer(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(7, 0)),
                     1'($urandom), $urandom, int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_xfer(1'(n % 2), 16'(n * 4 + 1), $urandom, 0, 1'b0, $urandom, 0);
        end
    endtask

    initial begin
        preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        @(negedge pclk);
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfs_apb_master.md
Name: cfs_apb_master

Overview:
Upstream stage of the APB interface. It converts a simple valid/ready request/response channel into APB protocol transfers and drives the bus. It performs one transfer at a time: setup phase, then access phase with wait states. It returns read data and error status upstream. A configurable timeout aborts transfers when the slave never asserts pready.

Parameters:
CFS_APB_MAX_ADDR_WIDTH, 16, width of paddr/req_addr
CFS_APB_MAX_DATA_WIDTH, 32, width of pwdata/prdata/req_wdata/rsp_rdata
TIMEOUT_CYCLES, 255, access-phase cycles without pready before abort; 0 disables timeout

Ports:
pclk  in  1  clock; one clock domain, all logic on rising edge
preset  in  1  reset, synchronous, active-high
req_valid  in  1  upstream request valid
req_ready  out  1  block accepts request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  upstream accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address, bits [1:0] always 0
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  APB ready
prdata  in  DATA_WIDTH  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Interface: one clock (pclk); reset (preset) is synchronous and active-high.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, FSM=IDLE, timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 (registered state decode).
  - req_valid&&req_ready captures write/addr/wdata into registers, with addr[1:0] forced to 0. Next state is SETUP.
- SETUP:
  - psel=1, penable=0; paddr/pwrite/pwdata driven from captured registers.
  - Lasts exactly 1 cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - Counter increments each cycle pready=0.
  - pready=1: latch rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr; rsp_timeout=0. Next state is RESP; psel/penable low the following cycle.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES with pready=0: abort. rsp_err=1, rsp_timeout=1, rsp_rdata=0; next state is RESP.
  - pready in the same cycle as the timeout threshold: pready wins; normal completion.
- RESP:
  - psel=0, penable=0, rsp_valid=1; response fields stable until rsp_valid&&rsp_ready, then IDLE.
  - No new request is accepted in RESP (req_ready=0).
- Latency (zero-wait slave):
  - Request accepted at edge T; SETUP cycle T+1; ACCESS cycle T+2 with pready sampled.
  - rsp_valid=1 in cycle T+3.
  - Best-case back-to-back throughput is 1 transfer per 4 cycles (with rsp_ready tied high).
- pslverr is only sampled when psel&&penable&&pready; ignored otherwise. prdata is ignored for writes.
- Counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset mid-operation: next edge forces reset values. Any in-flight transfer and pending response are discarded; psel drops immediately even in ACCESS.
- Upstream inputs are don't-care outside IDLE; req_* changes during a transfer have no effect.

Test Plan:
- Write, zero-wait: req_write=1, addr=0x0013, wdata=0xDEADBEEF → SETUP psel=1/penable=0 paddr=0x0010 pwrite=1; next cycle penable=1; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: addr=0x0100; pready low for 3 ACCESS cycles then high with prdata=0xA5A5_1234 → psel/penable/paddr stable for 4 ACCESS cycles; rsp_rdata=0xA5A51234, rsp_err=0.
- Slave error: read with pslverr=1 on pready → rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 → abort after 4 stalled ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0 next cycle. Variant with pready=1 exactly at the threshold → normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid and fields held, req_ready=0, no APB activity; release → IDLE and next request accepted.
- Reset mid-ACCESS: assert preset during ACCESS → next cycle psel=0, penable=0, rsp_valid=0, req_ready=0. After deassertion, a new read completes normally.
